change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream of the balance/dispense stage. On a start pulse it takes the leftover credit and pays it out as change.
- Change is paid one coin at a time to the coin-ejector mechanism, using a greedy quarter/dime/nickel algorithm.
- Each coin uses a valid/ack handshake. The block reports busy, done and error status to the top level and display.

Parameters:
- MAX_AMOUNT, 95, largest accepted change amount in cents; larger requests are rejected.
- ACK_TIMEOUT, 1023, cycles to wait for coin_ack before flagging a jam (used only with the optional feature).
- CNT_W, 10, width of the timeout counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting 0 clears all state immediately.
- start  input  1  one-cycle request to pay out amount; sampled only in IDLE.
- amount  input  7  change in cents, unsigned, sampled on start.
- coin_ack  input  1  ejector has released the presented coin.
- coin_out  output  3  coin code presented; same encoding as coin input codes.
- coin_valid  output  1  coin_out is valid and awaiting ack.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse when the full amount has been paid.
- error  output  1  sticky; cleared only by reset or the next accepted start.
- remaining  output  7  cents still to pay.

Behaviour:
- Reset values: coin_out=0 (NONE), coin_valid=0, busy=0, done=0, error=0, remaining=0; FSM in IDLE.
- Coin codes (package): NONE=0, NICKEL=1 (5c), DIME=2 (10c), QUARTER=3 (25c). Codes 4–7 are never produced.
- State IDLE:
  - On start, clear error.
  - If amount > MAX_AMOUNT, or amount mod 5 != 0: set error=1 and stay in IDLE; pulse nothing.
  - Else if amount==0: pulse done next cycle via DONE; busy stays 0.
  - Else: load remaining=amount, go to SELECT.
  - start while not IDLE is ignored.
- State SELECT (1 cycle):
  - coin = QUARTER if remaining>=25, else DIME if remaining>=10, else NICKEL.
  - Register coin_out and set coin_valid=1; go to PRESENT.
- State PRESENT:
  - Hold coin_out and coin_valid stable until coin_ack=1.
  - On ack in the same cycle: coin_valid=0, coin_out=NONE, remaining -= coin value.
  - If the new remaining==0 go to DONE, else go to SELECT.
  - coin_ack outside PRESENT is ignored.
- State DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in SELECT, PRESENT and DONE.
- Latency: first coin_valid rises 2 cycles after start. Each subsequent coin appears 2 cycles after the previous ack.
- Example: 40c gives Q, D, Q? No — greedy gives Q, D, N (25+10+5).
- Arithmetic: remaining is 7-bit unsigned. It never underflows, because the chosen coin is always <= remaining.
- Reset mid-payout: abort immediately. Coins already acked are not reissued and remaining is lost.

Optional Feature:
- Macro CHANGE_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit counter clears on entry to PRESENT and increments each cycle without ack.
  - On reaching ACK_TIMEOUT: set error=1, drop coin_valid, set coin_out=NONE, go to IDLE (busy=0, no done).
  - remaining holds the unpaid amount for the display.
- Not defined: no counter exists, and PRESENT waits for ack indefinitely.

Decomposition:
- Shared package vend_pkg:
  - coin code localparams NONE/NICKEL/DIME/QUARTER
  - coin value constants 5/10/25
  - MAX_AMOUNT default
  - FSM state encodings IDLE/SELECT/PRESENT/DONE
- Natural sub-module: coin_select, a combinational greedy picker (remaining -> coin code, coin value). It is shared with any future change-availability check.

Test Plan:
- Reset low mid-PRESENT -> all outputs return to reset values at once; after reset release, start amount=15 pays D, N and then done.
- start amount=65, ack 3 cycles after each valid -> coins Q, Q, D, N; remaining 40, 15, 5, 0; done one cycle after the final ack; busy falls with done.
- start amount=0 -> done pulse, no coin_valid, error=0.
- start amount=100, then start amount=7 -> error=1 each time, busy never rises; then start amount=5 clears error and pays one N.
- Second start asserted during PRESENT of amount=30 -> ignored; exactly Q, N are paid.
- With CHANGE_TIMEOUT_EN and ACK_TIMEOUT=8: start amount=35, ack the Q, never ack the D -> error=1 after 8 cycles, coin_valid=0, remaining=10, no done pulse.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, coin values, amount limits and the
// change-dispenser FSM state encoding.
package vend_pkg;

  localparam int unsigned CoinW = 3;
  localparam int unsigned AmtW  = 7;

  typedef logic [CoinW-1:0] coin_t;

  // Coin codes; 4..7 are never produced
  localparam coin_t CoinNone    = 3'd0;
  localparam coin_t CoinNickel  = 3'd1;
  localparam coin_t CoinDime    = 3'd2;
  localparam coin_t CoinQuarter = 3'd3;

  // Coin values in cents
  localparam logic [AmtW-1:0] ValNickel  = 7'd5;
  localparam logic [AmtW-1:0] ValDime    = 7'd10;
  localparam logic [AmtW-1:0] ValQuarter = 7'd25;

  localparam int unsigned MaxAmountDefault = 95;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StPresent,
    StDone
  } disp_state_e;

  // A payable request is within range and a whole number of nickels.
  function automatic logic amount_ok(logic [AmtW-1:0] amt, int unsigned max_amt);
    return ({25'd0, amt} <= max_amt) && ((amt % 7'd5) == 7'd0);
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin not exceeding the remaining amount.
// Purely combinational; for remaining < 5 it still answers NICKEL, so callers
// only consult it while a payout is outstanding.
//   remaining_i : cents still owed
//   coin_o      : coin code to present
//   value_o     : value of coin_o in cents
module coin_select
  import vend_pkg::*;
(
  input  logic [AmtW-1:0] remaining_i,
  output coin_t           coin_o,
  output logic [AmtW-1:0] value_o
);

  always_comb begin
    if (remaining_i >= ValQuarter) begin
      coin_o  = CoinQuarter;
      value_o = ValQuarter;
    end else if (remaining_i >= ValDime) begin
      coin_o  = CoinDime;
      value_o = ValDime;
    end else begin
      coin_o  = CoinNickel;
      value_o = ValNickel;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: on start, pays the requested amount one coin at a time
// (greedy Q/D/N) over a valid/ack handshake to the coin ejector.
// Optional ack-timeout jam detection is built when CHANGE_TIMEOUT_EN is defined.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   start_i        : pay request, honoured only when idle
//   amount_i       : cents to pay, sampled with start_i
//   coin_ack_i     : ejector released the presented coin
//   coin_out_o     : presented coin code (NONE when nothing presented)
//   coin_valid_o   : coin_out_o awaits ack
//   busy_o         : payout in progress
//   done_o         : one-cycle pulse when the full amount is paid
//   error_o        : sticky bad-request / jam flag, cleared by next start
//   remaining_o    : cents still owed
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned MAX_AMOUNT  = MaxAmountDefault,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned CNT_W       = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [AmtW-1:0] amount_i,
  input  logic            coin_ack_i,
  output coin_t           coin_out_o,
  output logic            coin_valid_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [AmtW-1:0] remaining_o
);

  if (MAX_AMOUNT > 127 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $error("change_dispenser: invalid parameterization");
  end

  disp_state_e     state_q, state_d;
  coin_t           coin_q, coin_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            error_q, error_d;
  logic [AmtW-1:0] rem_q, rem_d;

  coin_t           sel_coin;
  logic [AmtW-1:0] sel_value;

  // rem_q is frozen between SELECT and the ack, so sel_value is also the value
  // of the coin currently presented.
  coin_select u_coin_select (
    .remaining_i (rem_q),
    .coin_o      (sel_coin),
    .value_o     (sel_value)
  );

`ifdef CHANGE_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    error_d = error_q;
    rem_d   = rem_q;
`ifdef CHANGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          error_d = 1'b0;
          if (!amount_ok(amount_i, MAX_AMOUNT)) begin
            error_d = 1'b1;
          end else if (amount_i == '0) begin
            // Zero payout still reports done, but never looks busy
            state_d = StDone;
          end else begin
            rem_d   = amount_i;
            busy_d  = 1'b1;
            state_d = StSelect;
          end
        end
      end
      StSelect: begin
        coin_d  = sel_coin;
        valid_d = 1'b1;
        state_d = StPresent;
`ifdef CHANGE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StPresent: begin
        if (coin_ack_i) begin
          valid_d = 1'b0;
          coin_d  = CoinNone;
          rem_d   = rem_q - sel_value;
          state_d = (rem_q == sel_value) ? StDone : StSelect;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Jam: abandon the payout, leaving the unpaid amount visible
          error_d = 1'b1;
          valid_d = 1'b0;
          coin_d  = CoinNone;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      coin_q  <= CoinNone;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      rem_q   <= '0;
`ifdef CHANGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      error_q <= error_d;
      rem_q   <= rem_d;
`ifdef CHANGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign coin_out_o   = coin_q;
  assign coin_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = (state_q == StDone);
  assign error_o      = error_q;
  assign remaining_o  = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a transaction-level model (greedy
// coin list computed by division, handshake timing as countdowns) is compared
// against every DUT output on every cycle, plus literal spot checks.
module tb_change_dispenser;
  import vend_pkg::*;

  localparam int AckTo = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] amount = '0;
  logic       ack = 1'b0;
  logic [2:0] coin_out;
  logic       coin_valid, busy, done, error;
  logic [6:0] remaining;

  always #5 clk = ~clk;

  change_dispenser #(
    .MAX_AMOUNT  (95),
    .ACK_TIMEOUT (AckTo),
    .CNT_W       (10)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .amount_i     (amount),
    .coin_ack_i   (ack),
    .coin_out_o   (coin_out),
    .coin_valid_o (coin_valid),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .remaining_o  (remaining)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit m_idle, m_wait, m_valid, m_busy, m_done, m_err;
  int m_coin, m_rem, m_tcnt;
  int m_q[$];

  function automatic int coin_val(input int c);
    return (c == 3) ? 25 : (c == 2) ? 10 : (c == 1) ? 5 : 0;
  endfunction

  function automatic void plan(input int amt);
    int r;
    m_q.delete();
    repeat (amt / 25) m_q.push_back(3);
    r = amt % 25;
    repeat (r / 10) m_q.push_back(2);
    r = r % 10;
    repeat (r / 5) m_q.push_back(1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1; m_wait <= 1'b0; m_valid <= 1'b0; m_busy <= 1'b0;
      m_done <= 1'b0; m_err <= 1'b0; m_coin <= 0; m_rem <= 0; m_tcnt <= 0;
      m_q.delete();
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0; m_idle <= 1'b1;
    end else if (m_idle) begin
      if (start) begin
        if (int'(amount) > 95 || int'(amount) % 5 != 0) m_err <= 1'b1;
        else begin
          m_err <= 1'b0;
          m_idle <= 1'b0;
          if (amount == 0) m_done <= 1'b1;
          else begin
            m_rem <= int'(amount); plan(int'(amount)); m_busy <= 1'b1; m_wait <= 1'b1;
          end
        end
      end
    end else if (m_wait) begin
      m_wait <= 1'b0; m_valid <= 1'b1; m_coin <= m_q[0]; m_tcnt <= 0;
    end else if (m_valid) begin
      if (ack) begin
        m_valid <= 1'b0;
        m_rem <= m_rem - coin_val(m_coin);
        m_coin <= 0;
        if (m_q.size() == 1) m_done <= 1'b1;
        else m_wait <= 1'b1;
        void'(m_q.pop_front());
      end
`ifdef CHANGE_TIMEOUT_EN
      else if (m_tcnt + 1 == AckTo) begin
        m_err <= 1'b1; m_valid <= 1'b0; m_coin <= 0; m_busy <= 1'b0; m_idle <= 1'b1;
      end else begin
        m_tcnt <= m_tcnt + 1;
      end
`endif
    end
  end

  // Per-cycle compare
  always @(negedge clk) begin
    if (rst_n) begin
      chk("coin_out", int'(coin_out), m_coin);
      chk("coin_valid", int'(coin_valid), int'(m_valid));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("error", int'(error), int'(m_err));
      chk("remaining", int'(remaining), m_rem);
    end
  end

  // ---------------- monitors ----------------
  int log_coin[$];
  int log_rem[$];
  bit pend_rem = 1'b0;
  int n_done = 0, n_valid = 0, n_busy = 0;

  always @(posedge clk) begin
    pend_rem <= rst_n && coin_valid && ack;
    if (rst_n && coin_valid && ack) log_coin.push_back(int'(coin_out));
  end

  always @(negedge clk) begin
    if (pend_rem) log_rem.push_back(int'(remaining));
    n_done  <= n_done + int'(done);
    n_valid <= n_valid + int'(coin_valid);
    n_busy  <= n_busy + int'(busy);
  end

  // ---------------- ack responder ----------------
  int ack_delay = 0;
  int ack_budget = -1;
  bit ack_noise = 1'b0;

  initial begin : responder
    int waitc;
    waitc = 0;
    forever begin
      @(negedge clk);
      if (coin_valid && !ack) begin
        if (ack_budget != 0 && waitc >= ack_delay) begin
          ack = 1'b1;
          waitc = 0;
          if (ack_budget > 0) ack_budget--;
        end else begin
          ack = 1'b0;
          waitc++;
        end
      end else begin
        waitc = 0;
        ack = (!coin_valid && ack_noise) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input int a);
    amount = 7'(a);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(m_idle && !m_done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " settles"}, int'(n < 400), 1);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!coin_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " coin_valid rises"}, int'(n < 50), 1);
  endtask

  task automatic check_log(input string nm, input int ec[$], input int er[$]);
    chk({nm, " coin count"}, log_coin.size(), ec.size());
    for (int i = 0; i < ec.size(); i++) begin
      chk($sformatf("%s coin[%0d]", nm, i), (i < log_coin.size()) ? log_coin[i] : -1, ec[i]);
      chk($sformatf("%s rem[%0d]", nm, i), (i < log_rem.size()) ? log_rem[i] : -1, er[i]);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, " coin_out"}, int'(coin_out), 0);
    chk({nm, " coin_valid"}, int'(coin_valid), 0);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " error"}, int'(error), 0);
    chk({nm, " remaining"}, int'(remaining), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ec[$];
    int er[$];
    int base_d, base_v, base_b, k, a, n;

    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 65c, ack 3 cycles after each valid
    ack_delay = 3;
    log_coin.delete(); log_rem.delete(); base_d = n_done;
    pulse_start(65);
    wait_idle("pay65");
    ec = {3, 3, 2, 1}; er = {40, 15, 5, 0};
    check_log("pay65", ec, er);
    chk("pay65 done pulses", n_done - base_d, 1);

    // Zero amount
    base_d = n_done; base_v = n_valid; base_b = n_busy;
    pulse_start(0);
    wait_idle("pay0");
    chk("pay0 done pulses", n_done - base_d, 1);
    chk("pay0 valid cycles", n_valid - base_v, 0);
    chk("pay0 busy cycles", n_busy - base_b, 0);
    chk("pay0 error", int'(error), 0);

    // Bad requests, then a good one clears error
    base_b = n_busy;
    pulse_start(100);
    chk("amt100 error", int'(error), 1);
    @(negedge clk);
    pulse_start(7);
    chk("amt7 error", int'(error), 1);
    @(negedge clk);
    chk("bad starts busy cycles", n_busy - base_b, 0);
    ack_delay = 0;
    log_coin.delete(); log_rem.delete();
    pulse_start(5);
    chk("amt5 error cleared", int'(error), 0);
    wait_idle("pay5");
    ec = {1}; er = {0};
    check_log("pay5", ec, er);

    // Second start during PRESENT is ignored
    ack_delay = 4;
    log_coin.delete(); log_rem.delete();
    pulse_start(30);
    wait_valid("pay30");
    pulse_start(45);
    wait_idle("pay30");
    ec = {3, 1}; er = {5, 0};
    check_log("pay30", ec, er);

    // Reset mid-PRESENT
    ack_delay = 1000;
    pulse_start(65);
    wait_valid("rst65");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid-reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_delay = 1;
    log_coin.delete(); log_rem.delete(); base_d = n_done;
    pulse_start(15);
    wait_idle("pay15");
    ec = {2, 1}; er = {5, 0};
    check_log("pay15", ec, er);
    chk("pay15 done pulses", n_done - base_d, 1);

`ifdef CHANGE_TIMEOUT_EN
    // Jam on the second coin
    ack_delay = 1; ack_budget = 1;
    log_coin.delete(); log_rem.delete(); base_d = n_done; base_v = n_valid;
    pulse_start(35);
    wait_idle("jam35");
    ack_budget = -1;
    chk("jam error", int'(error), 1);
    chk("jam coin_valid", int'(coin_valid), 0);
    chk("jam remaining", int'(remaining), 10);
    chk("jam done pulses", n_done - base_d, 0);
    chk("jam valid cycles", n_valid - base_v, 10);
    @(negedge clk);
`endif

    // Randomized traffic, with ignored starts while busy and stray acks
    for (int t = 0; t < 40; t++) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) a = 0;
      else if (k == 1) a = int'($urandom_range(96, 127));
      else if (k == 2) a = 5 * int'($urandom_range(0, 18)) + int'($urandom_range(1, 4));
      else a = 5 * int'($urandom_range(1, 19));
      ack_delay = int'($urandom_range(0, 4));
      ack_noise = 1'($urandom_range(0, 1));
      pulse_start(a);
      n = 0;
      while (!(m_idle && !m_done) && n < 400) begin
        if ($urandom_range(0, 7) == 0) begin
          amount = 7'($urandom_range(0, 127));
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      chk("random settles", int'(n < 400), 1);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end
    ack_noise = 1'b0;

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
